// File: rtl/sigmul_pkg.sv
// Shared widths for the significand multiply / round datapath.
package sigmul_pkg;

  // Fraction width without the hidden bit (10 -> binary16).
  localparam int NSIG_DEF = 10;

  // Exponent increment out of the rounder spans 0..2.
  localparam int EINCW = 2;

  // Significand width including the hidden bit.
  function automatic int sig_width(input int nsig);
    return nsig + 1;
  endfunction

  // Raw product width of two significands.
  function automatic int prod_width(input int nsig);
    return 2 * nsig + 2;
  endfunction

endpackage

// File: rtl/sigprod_rne.sv
// Round-to-nearest-even on a normalized significand with guard/sticky.
// A carry out of the significand renormalizes to 1.00..0 and bumps the exponent.
module sigprod_rne
  import sigmul_pkg::*;
#(
  parameter int NSIG = NSIG_DEF
) (
  input  logic [NSIG:0]      sig_n,
  input  logic               guard,
  input  logic               sticky,
  input  logic               einc1,
  output logic [NSIG:0]      sig,
  output logic [EINCW-1:0]   einc,
  output logic               inexact
);

  logic            rup;
  logic [NSIG+1:0] sum;

  // Increment on more-than-half, or exactly half with an odd lsb.
  always_comb begin
    rup     = guard & (sticky | sig_n[0]);
    sum     = {1'b0, sig_n} + {{(NSIG + 1){1'b0}}, rup};
    inexact = guard | sticky;
    if (sum[NSIG+1]) begin
      sig  = sum[NSIG+1:1];
      einc = EINCW'(einc1) + EINCW'(1);
    end else begin
      sig  = sum[NSIG:0];
      einc = EINCW'(einc1);
    end
  end

endmodule

// File: rtl/sigprod_round.sv
// Normalize and round a raw significand product.
// Stage 1 registers the normalized significand with guard/sticky; stage 2
// registers the rounded result. Plain valid/ready pipeline, one result per cycle.
module sigprod_round
  import sigmul_pkg::*;
#(
  parameter int NSIG = NSIG_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*NSIG+1:0]      in_p,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NSIG:0]          out_sig,
  output logic [EINCW-1:0]       out_einc,
  output logic                   out_inexact,
  output logic                   out_zero
);

  localparam int SIGW  = sig_width(NSIG);
  localparam int PRODW = prod_width(NSIG);

  logic s1_en;
  logic s2_en;

  logic [SIGW-1:0] nrm_sig;
  logic            nrm_guard;
  logic            nrm_sticky;
  logic            nrm_einc;
  logic            nrm_zero;

  logic            s1_valid_q,  s1_valid_d;
  logic [SIGW-1:0] s1_sig_q,    s1_sig_d;
  logic            s1_guard_q,  s1_guard_d;
  logic            s1_sticky_q, s1_sticky_d;
  logic            s1_einc_q,   s1_einc_d;
  logic            s1_zero_q,   s1_zero_d;

  logic [SIGW-1:0]  rne_sig;
  logic [EINCW-1:0] rne_einc;
  logic             rne_inexact;

  logic             s2_valid_q,   s2_valid_d;
  logic [SIGW-1:0]  s2_sig_q,     s2_sig_d;
  logic [EINCW-1:0] s2_einc_q,    s2_einc_d;
  logic             s2_inexact_q, s2_inexact_d;
  logic             s2_zero_q,    s2_zero_d;

  // Stage enables: a stage may load when empty or when its contents move on.
  always_comb begin
    s2_en    = ~s2_valid_q | out_ready;
    s1_en    = ~s1_valid_q | s2_en;
    in_ready = s1_en;
  end

  // Normalize: right-shift by one when the product has a carry into the top bit.
  // Products below 1.0 (top two bits 00) are passed through unshifted.
  always_comb begin
    if (in_p[PRODW-1]) begin
      nrm_sig    = in_p[PRODW-1:NSIG+1];
      nrm_guard  = in_p[NSIG];
      nrm_sticky = |in_p[NSIG-1:0];
      nrm_einc   = 1'b1;
    end else begin
      nrm_sig    = in_p[PRODW-2:NSIG];
      nrm_guard  = in_p[NSIG-1];
      nrm_sticky = |in_p[NSIG-2:0];
      nrm_einc   = 1'b0;
    end
    nrm_zero = (in_p == '0);
  end

  // Stage 1 next-state: capture a normalized product on an input transfer.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sig_d    = s1_sig_q;
    s1_guard_d  = s1_guard_q;
    s1_sticky_d = s1_sticky_q;
    s1_einc_d   = s1_einc_q;
    s1_zero_d   = s1_zero_q;
    if (s1_en) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sig_d    = nrm_sig;
        s1_guard_d  = nrm_guard;
        s1_sticky_d = nrm_sticky;
        s1_einc_d   = nrm_einc;
        s1_zero_d   = nrm_zero;
      end
    end
  end

  sigprod_rne #(
    .NSIG (NSIG)
  ) u_rne (
    .sig_n   (s1_sig_q),
    .guard   (s1_guard_q),
    .sticky  (s1_sticky_q),
    .einc1   (s1_einc_q),
    .sig     (rne_sig),
    .einc    (rne_einc),
    .inexact (rne_inexact)
  );

  // Stage 2 next-state: capture the rounded result; a zero product forces
  // every other field to zero so the pack stage sees a clean encoding.
  always_comb begin
    s2_valid_d   = s2_valid_q;
    s2_sig_d     = s2_sig_q;
    s2_einc_d    = s2_einc_q;
    s2_inexact_d = s2_inexact_q;
    s2_zero_d    = s2_zero_q;
    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        if (s1_zero_q) begin
          s2_sig_d     = '0;
          s2_einc_d    = '0;
          s2_inexact_d = 1'b0;
          s2_zero_d    = 1'b1;
        end else begin
          s2_sig_d     = rne_sig;
          s2_einc_d    = rne_einc;
          s2_inexact_d = rne_inexact;
          s2_zero_d    = 1'b0;
        end
      end
    end
  end

  // Pipeline registers; reset empties both stages and clears all data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sig_q     <= '0;
      s1_guard_q   <= 1'b0;
      s1_sticky_q  <= 1'b0;
      s1_einc_q    <= 1'b0;
      s1_zero_q    <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_sig_q     <= '0;
      s2_einc_q    <= '0;
      s2_inexact_q <= 1'b0;
      s2_zero_q    <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sig_q     <= s1_sig_d;
      s1_guard_q   <= s1_guard_d;
      s1_sticky_q  <= s1_sticky_d;
      s1_einc_q    <= s1_einc_d;
      s1_zero_q    <= s1_zero_d;
      s2_valid_q   <= s2_valid_d;
      s2_sig_q     <= s2_sig_d;
      s2_einc_q    <= s2_einc_d;
      s2_inexact_q <= s2_inexact_d;
      s2_zero_q    <= s2_zero_d;
    end
  end

  // Outputs come straight from the stage-2 registers.
  always_comb begin
    out_valid   = s2_valid_q;
    out_sig     = s2_sig_q;
    out_einc    = s2_einc_q;
    out_inexact = s2_inexact_q;
    out_zero    = s2_zero_q;
  end

endmodule

// File: tb/tb_sigprod_round.sv
// Bench for sigprod_round: directed corner products, backpressure, mid-stream
// reset and a randomized stream scored against an arithmetic rounding model.
module tb_sigprod_round;

  localparam int N = 10;

  typedef struct packed {
    logic [N:0] sig;
    logic [1:0] einc;
    logic       inexact;
    logic       zero;
  } res_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2*N+1:0]  in_p = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [N:0]      out_sig;
  logic [1:0]      out_einc;
  logic            out_inexact;
  logic            out_zero;

  int   n_vec = 0;
  int   n_err = 0;
  int   out_count = 0;
  res_t sb[$];
  logic stall_prev = 1'b0;
  res_t held;

  sigprod_round #(.NSIG(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_p        (in_p),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sig     (out_sig),
    .out_einc    (out_einc),
    .out_inexact (out_inexact),
    .out_zero    (out_zero)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: scale the product down to N+1 bits by plain division and
  // round the discarded remainder to nearest, ties to even.
  function automatic res_t ref_round(input logic [2*N+1:0] p);
    res_t r;
    longint unsigned pv, sig, rem, half;
    int k;
    r = '0;
    pv = 64'(p);
    if (pv == 0) begin
      r.zero = 1'b1;
      return r;
    end
    k    = (pv >= (64'd1 << (2*N+1))) ? N + 1 : N;
    sig  = pv / (64'd1 << k);
    rem  = pv % (64'd1 << k);
    half = 64'd1 << (k - 1);
    if (rem > half || (rem == half && (sig % 2) == 1)) sig = sig + 1;
    r.einc = (k == N + 1) ? 2'd1 : 2'd0;
    if (sig == (64'd1 << (N + 1))) begin
      sig    = sig / 2;
      r.einc = r.einc + 2'd1;
    end
    r.sig     = (N+1)'(sig);
    r.inexact = (rem != 0);
    return r;
  endfunction

  function automatic logic [2*N+1:0] rand_prod();
    logic [2*N+1:0] p;
    p = (2*N+2)'($urandom);
    case ($urandom_range(0, 7))
      0: p = '0;
      1: begin
        if (p[2*N+1]) begin p[N] = 1'b1; p[N-1:0] = '0; end
        else begin p[N-1] = 1'b1; p[N-2:0] = '0; end
      end
      2: p = '1;
      3: p = (2*N+2)'($urandom_range(1, 1023));
      default: ;
    endcase
    return p;
  endfunction

  // Called just after a falling edge: drives inputs for the coming rising edge,
  // then scores what the DUT presents and what it will transfer.
  task automatic drive(input logic v, input logic [2*N+1:0] p, input logic ordy, output logic acc);
    res_t e;
    in_valid  = v;
    in_p      = p;
    out_ready = ordy;
    #1;
    if (stall_prev) begin
      check_val("hold_valid", 32'(out_valid), 32'd1);
      check_val("hold_data", 32'({out_sig, out_einc, out_inexact, out_zero}), 32'(held));
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_val("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("out_sig", 32'(out_sig), 32'(e.sig));
        check_val("out_einc", 32'(out_einc), 32'(e.einc));
        check_val("out_inexact", 32'(out_inexact), 32'(e.inexact));
        check_val("out_zero", 32'(out_zero), 32'(e.zero));
      end
      out_count++;
    end
    stall_prev = out_valid && !out_ready;
    held = {out_sig, out_einc, out_inexact, out_zero};
    acc = in_valid && in_ready;
    if (acc) sb.push_back(ref_round(in_p));
  endtask

  logic [2*N+1:0] dir_p   [5] = '{22'h100000, 22'h3FF001, 22'h1FFE00, 22'h100200, 22'h000000};
  logic [N:0]     dir_sig [5] = '{11'h400, 11'h7FE, 11'h400, 11'h400, 11'h000};
  logic [1:0]     dir_einc[5] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
  logic           dir_inx [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic           dir_zero[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    logic acc;
    logic saw_drop;
    int   sent, stall_left, base;
    logic [2*N+1:0] bp_p [4];

    // Reset state
    #3;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_data", 32'({out_sig, out_einc, out_inexact, out_zero}), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner products with latency check
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive(1'b1, dir_p[i], 1'b1, acc);
      check_val("dir_accept", 32'(acc), 32'd1);
      @(negedge clk); drive(1'b0, '0, 1'b1, acc);
      check_val("dir_lat1", 32'(out_valid), 32'd0);
      @(negedge clk); drive(1'b0, '0, 1'b1, acc);
      check_val("dir_lat2", 32'(out_valid), 32'd1);
      check_val("dir_sig", 32'(out_sig), 32'(dir_sig[i]));
      check_val("dir_einc", 32'(out_einc), 32'(dir_einc[i]));
      check_val("dir_inexact", 32'(out_inexact), 32'(dir_inx[i]));
      check_val("dir_zero", 32'(out_zero), 32'(dir_zero[i]));
    end

    // Backpressure: 4 back-to-back, consumer stalls 3 cycles at first result
    for (int i = 0; i < 4; i++) bp_p[i] = rand_prod();
    sent = 0; stall_left = 3; saw_drop = 1'b0; base = out_count;
    for (int c = 0; c < 40 && (out_count - base) < 4; c++) begin
      @(negedge clk);
      if (out_valid && stall_left > 0) begin
        stall_left--;
        drive(sent < 4, (sent < 4) ? bp_p[sent] : '0, 1'b0, acc);
        if (in_valid && !in_ready) saw_drop = 1'b1;
      end else begin
        drive(sent < 4, (sent < 4) ? bp_p[sent] : '0, 1'b1, acc);
      end
      if (acc) sent++;
    end
    check_val("bp_in_ready_drop", 32'(saw_drop), 32'd1);
    check_val("bp_count", 32'(out_count - base), 32'd4);

    // Reset mid-stream with two items in flight
    @(negedge clk); drive(1'b1, rand_prod(), 1'b1, acc);
    @(negedge clk); drive(1'b1, rand_prod(), 1'b1, acc);
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", 32'(out_valid), 32'd0);
    check_val("midrst_out_data", 32'({out_sig, out_einc, out_inexact, out_zero}), 32'd0);
    #1 rst_n = 1'b1;
    sb.delete();
    stall_prev = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); drive(1'b0, '0, 1'b1, acc);
      check_val("postrst_in_ready", 32'(in_ready), 32'd1);
      check_val("postrst_no_stale", 32'(out_valid), 32'd0);
    end

    // Randomized stream against the reference model
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      drive($urandom_range(0, 3) != 0, rand_prod(), $urandom_range(0, 3) != 0, acc);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); drive(1'b0, '0, 1'b1, acc);
    end
    check_val("drain_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
